// File: rtl/pe_pkg.sv
// Shared definitions for the weight-stationary SIMD PE.
// Mode encodings, sign-bit positions and lane-count decode.
package pe_pkg;

   typedef enum logic [1:0] {
      MODE_1X  = 2'b00,
      MODE_2X  = 2'b01,
      MODE_4X  = 2'b10,
      MODE_RSV = 2'b11
   } simd_mode_e;

   localparam int SIGN_ACT = 0;
   localparam int SIGN_WGT = 1;

   // Reserved encoding falls back to a single full-width lane.
   function automatic logic [2:0] lane_cnt(input logic [1:0] mode);
      case (mode)
         MODE_2X: return 3'd2;
         MODE_4X: return 3'd4;
         default: return 3'd1;
      endcase
   endfunction

endpackage

// File: rtl/pe_simd_ws_if.sv
// Port bundle of one PE: control, weight chain, activation
// and partial-sum paths.
interface pe_simd_ws_if #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 32
);
   logic              en;
   logic [1:0]        simd_mode;
   logic [DATA_W-1:0] weight_in;
   logic              weight_load;
   logic              weight_swap;
   logic [DATA_W-1:0] matrix_in;
   logic [1:0]        matrix_sign_in;
   logic              matrix_valid_in;
   logic [ACC_W-1:0]  sum_in;
   logic              sat_clr;
   logic [DATA_W-1:0] weight_out;
   logic [DATA_W-1:0] matrix_out;
   logic [1:0]        matrix_sign_out;
   logic              matrix_valid_out;
   logic [ACC_W-1:0]  sum_out;
   logic              sum_valid_out;
   logic              sat_flag;

   modport master (
      output en, simd_mode, weight_in,
      output weight_load, weight_swap,
      output matrix_in, matrix_sign_in,
      output matrix_valid_in, sum_in, sat_clr,
      input  weight_out, matrix_out,
      input  matrix_sign_out, matrix_valid_out,
      input  sum_out, sum_valid_out, sat_flag
   );

   modport slave (
      input  en, simd_mode, weight_in,
      input  weight_load, weight_swap,
      input  matrix_in, matrix_sign_in,
      input  matrix_valid_in, sum_in, sat_clr,
      output weight_out, matrix_out,
      output matrix_sign_out, matrix_valid_out,
      output sum_out, sum_valid_out, sat_flag
   );
endinterface

// File: rtl/pe_lane_mac.sv
// One accumulator slice: W-bit add whose carry-in is cut
// when the slice starts a new lane.
module pe_lane_mac #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         c_prev,
   input  logic         brk,
   output logic [W-1:0] s,
   output logic         co
);

   logic ci;

   assign ci = c_prev & ~brk;

   assign {co, s} = {1'b0, a} + {1'b0, b}
                  + {{W{1'b0}}, ci};

endmodule

// File: rtl/pe_simd_ws.sv
// Weight-stationary systolic PE with 1/2/4-lane SIMD split,
// shadow/active weights and per-lane saturating accumulate.
module pe_simd_ws
   import pe_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 32,
   parameter bit SAT_EN = 1'b1
) (
   input logic         clk,
   input logic         rst,
   pe_simd_ws_if.slave io
);

   localparam int L2 = DATA_W / 2;
   localparam int L4 = DATA_W / 4;
   localparam int A2 = ACC_W / 2;
   localparam int A4 = ACC_W / 4;

   localparam logic [A4-1:0] MIN_TOP =
      {1'b1, {(A4-1){1'b0}}};
   localparam logic [A4-1:0] MAX_TOP =
      {1'b0, {(A4-1){1'b1}}};

   logic [DATA_W-1:0] shadow;
   logic [DATA_W-1:0] active;
   logic [DATA_W-1:0] mat_q;
   logic [1:0]        sgn_q;
   logic              s1_valid;
   logic [ACC_W-1:0]  s1_prod;
   logic [ACC_W-1:0]  s1_sum;
   logic [2:0]        s1_n;
   logic              s1_sgn;
   logic [ACC_W-1:0]  sum_q;
   logic              sv_q;
   logic              sat_q;

   logic [2:0]        n_in;
   logic              sa;
   logic              sw;
   logic [ACC_W-1:0]  prod;
   logic signed [DATA_W:0] a1, w1;
   logic signed [L2:0]     a2, w2;
   logic signed [L4:0]     a4, w4;
   logic signed [ACC_W-1:0] t;

   assign n_in = lane_cnt(io.simd_mode);
   assign sa   = io.matrix_sign_in[SIGN_ACT];
   assign sw   = io.matrix_sign_in[SIGN_WGT];

   // Lane products, each truncated/extended to its lane's
   // accumulator width.
   always_comb begin
      prod = '0;
      a1 = '0; w1 = '0;
      a2 = '0; w2 = '0;
      a4 = '0; w4 = '0;
      t  = '0;
      unique case (1'b1)
         (n_in == 3'd4): begin
            for (int i = 0; i < 4; i++) begin
               a4 = {sa & io.matrix_in[i*L4+L4-1],
                     io.matrix_in[i*L4 +: L4]};
               w4 = {sw & active[i*L4+L4-1],
                     active[i*L4 +: L4]};
               t = ACC_W'(a4) * ACC_W'(w4);
               prod[i*A4 +: A4] = t[A4-1:0];
            end
         end
         (n_in == 3'd2): begin
            for (int i = 0; i < 2; i++) begin
               a2 = {sa & io.matrix_in[i*L2+L2-1],
                     io.matrix_in[i*L2 +: L2]};
               w2 = {sw & active[i*L2+L2-1],
                     active[i*L2 +: L2]};
               t = ACC_W'(a2) * ACC_W'(w2);
               prod[i*A2 +: A2] = t[A2-1:0];
            end
         end
         default: begin
            a1 = {sa & io.matrix_in[DATA_W-1],
                  io.matrix_in};
            w1 = {sw & active[DATA_W-1], active};
            t = ACC_W'(a1) * ACC_W'(w1);
            prod = t;
         end
      endcase
   end

   logic [3:0]       brk;
   logic [3:0]       top;
   logic [3:0]       cy;
   logic [ACC_W-1:0] sl_sum;

   always_comb begin
      brk = 4'b0001;
      top = 4'b1000;
      unique case (1'b1)
         (s1_n == 3'd4): begin
            brk = 4'b1111;
            top = 4'b1111;
         end
         (s1_n == 3'd2): begin
            brk = 4'b0101;
            top = 4'b1010;
         end
         default: begin
            brk = 4'b0001;
            top = 4'b1000;
         end
      endcase
   end

   for (genvar k = 0; k < 4; k++) begin : g_sl
      logic          cp;
      logic          co;
      logic [A4-1:0] s;
      if (k == 0) begin : g_c0
         assign cp = 1'b0;
      end else begin : g_cn
         assign cp = g_sl[k-1].co;
      end
      pe_lane_mac #(.W(A4)) u_mac (
         .a      (s1_sum[k*A4 +: A4]),
         .b      (s1_prod[k*A4 +: A4]),
         .c_prev (cp),
         .brk    (brk[k]),
         .s      (s),
         .co     (co)
      );
      assign cy[k] = co;
      assign sl_sum[k*A4 +: A4] = s;
   end

   logic [ACC_W-1:0] res;
   logic             any_ovf;
   logic             lsat;
   logic             lneg;
   logic             ext;
   logic             msb;

   // The lane's top slice decides overflow; lower slices
   // of the same lane inherit its clamp direction.
   always_comb begin
      res     = sl_sum;
      any_ovf = 1'b0;
      lsat    = 1'b0;
      lneg    = 1'b0;
      ext     = 1'b0;
      msb     = 1'b0;
      for (int k = 3; k >= 0; k--) begin
         msb = sl_sum[k*A4+A4-1];
         ext = s1_sgn
             ? (s1_sum[k*A4+A4-1]
                ^ s1_prod[k*A4+A4-1] ^ cy[k])
             : cy[k];
         if (top[k]) begin
            lsat = s1_sgn ? (ext ^ msb) : ext;
            lneg = s1_sgn & ext;
            any_ovf = any_ovf | lsat;
         end
         if (SAT_EN && lsat) begin
            if (lneg)
               res[k*A4 +: A4] = top[k] ? MIN_TOP : '0;
            else if (top[k] && s1_sgn)
               res[k*A4 +: A4] = MAX_TOP;
            else
               res[k*A4 +: A4] = '1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow   <= '0;
         active   <= '0;
         mat_q    <= '0;
         sgn_q    <= '0;
         s1_valid <= 1'b0;
         s1_prod  <= '0;
         s1_sum   <= '0;
         s1_n     <= 3'd1;
         s1_sgn   <= 1'b0;
         sum_q    <= '0;
         sv_q     <= 1'b0;
         sat_q    <= 1'b0;
      end else if (io.en) begin
         mat_q    <= io.matrix_in;
         sgn_q    <= io.matrix_sign_in;
         s1_valid <= io.matrix_valid_in;
         s1_prod  <= prod;
         s1_sum   <= io.sum_in;
         s1_n     <= n_in;
         s1_sgn   <= |io.matrix_sign_in;
         if (io.weight_swap)
            active <= shadow;
         if (io.weight_load)
            shadow <= io.weight_in;
         sum_q <= res;
         sv_q  <= s1_valid;
         if (SAT_EN && s1_valid && any_ovf)
            sat_q <= 1'b1;
         else if (io.sat_clr)
            sat_q <= 1'b0;
      end
   end

   assign io.weight_out       = shadow;
   assign io.matrix_out       = mat_q;
   assign io.matrix_sign_out  = sgn_q;
   assign io.matrix_valid_out = s1_valid;
   assign io.sum_out          = sum_q;
   assign io.sum_valid_out    = sv_q;
   assign io.sat_flag         = sat_q;

endmodule
